// File: rtl/lbist_misr.sv
// LBIST multiple-input signature register: folds a requested number of
// CUT output words into a signature and returns it over a val/rdy response.
module lbist_misr #(
    parameter int          SIGNATURE_BITS      = 32,
    parameter int          CUT_OUTPUT_BITS     = 32,
    parameter int          MAX_OUTPUTS_TO_HASH = 32,
    parameter int          MISR_MSG_BITS       = $clog2(MAX_OUTPUTS_TO_HASH),
    parameter logic [31:0] POLY                = 32'h04C1_1DB7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       misr_req_val,
    output logic                       misr_req_rdy,
    input  logic [MISR_MSG_BITS:0]     misr_req_msg,
    input  logic                       cut_out_val,
    output logic                       cut_out_rdy,
    input  logic [CUT_OUTPUT_BITS-1:0] cut_out_msg,
    output logic                       misr_resp_val,
    input  logic                       misr_resp_rdy,
    output logic [SIGNATURE_BITS-1:0]  misr_resp_msg
);

    localparam int CW = MISR_MSG_BITS + 1;
    localparam int SB = SIGNATURE_BITS;
    localparam logic [SB-1:0] POLY_C = SB'(POLY);
    localparam logic [CW-1:0] MAX_C  = CW'(MAX_OUTPUTS_TO_HASH);

    typedef enum logic [1:0] {
        IDLE,
        HASH,
        DONE
    } state_t;

    state_t          state_q;
    logic [SB-1:0]   sig_q;
    logic [SB-1:0]   sig_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   tgt_q;
    logic [CW-1:0]   tgt_d;
    logic            req_rdy_q;
    logic            cut_rdy_q;
    logic            resp_val_q;

    always_comb begin
        sig_d = {sig_q[SB-2:0], 1'b0}
              ^ (sig_q[SB-1] ? POLY_C : '0)
              ^ SB'(cut_out_msg);
        tgt_d = (misr_req_msg > MAX_C) ? MAX_C : misr_req_msg;
    end

    // Handshake strobes are registered alongside the state so every
    // output is a flop and no input reaches an output combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sig_q      <= '0;
            cnt_q      <= '0;
            tgt_q      <= '0;
            req_rdy_q  <= 1'b1;
            cut_rdy_q  <= 1'b0;
            resp_val_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (misr_req_val) begin
                        tgt_q     <= tgt_d;
                        sig_q     <= '0;
                        cnt_q     <= '0;
                        req_rdy_q <= 1'b0;
                        if (tgt_d != '0) begin
                            state_q   <= HASH;
                            cut_rdy_q <= 1'b1;
                        end else begin
                            state_q    <= DONE;
                            resp_val_q <= 1'b1;
                        end
                    end
                end
                HASH: begin
                    if (cut_out_val) begin
                        sig_q <= sig_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == tgt_q - 1'b1) begin
                            state_q    <= DONE;
                            cut_rdy_q  <= 1'b0;
                            resp_val_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (misr_resp_rdy) begin
                        state_q    <= IDLE;
                        resp_val_q <= 1'b0;
                        req_rdy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    req_rdy_q  <= 1'b1;
                    cut_rdy_q  <= 1'b0;
                    resp_val_q <= 1'b0;
                end
            endcase
        end
    end

    assign misr_req_rdy  = req_rdy_q;
    assign cut_out_rdy   = cut_rdy_q;
    assign misr_resp_val = resp_val_q;
    assign misr_resp_msg = sig_q;

endmodule

// File: tb/tb_lbist_misr.sv
// Directed scoreboard bench for lbist_misr: expected signatures are queued
// when words are driven and popped when the response appears.
module tb_lbist_misr;

    logic        clk;
    logic        reset;
    logic        misr_req_val;
    logic        misr_req_rdy;
    logic [5:0]  misr_req_msg;
    logic        cut_out_val;
    logic        cut_out_rdy;
    logic [31:0] cut_out_msg;
    logic        misr_resp_val;
    logic        misr_resp_rdy;
    logic [31:0] misr_resp_msg;

    int n_assert = 0;
    int n_fail   = 0;
    int n_words  = 0;
    int n_reqs   = 0;
    logic [31:0] exp_q[$];

    lbist_misr dut (
        .clk           (clk),
        .reset         (reset),
        .misr_req_val  (misr_req_val),
        .misr_req_rdy  (misr_req_rdy),
        .misr_req_msg  (misr_req_msg),
        .cut_out_val   (cut_out_val),
        .cut_out_rdy   (cut_out_rdy),
        .cut_out_msg   (cut_out_msg),
        .misr_resp_val (misr_resp_val),
        .misr_resp_rdy (misr_resp_rdy),
        .misr_resp_msg (misr_resp_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset && cut_out_val && cut_out_rdy) n_words++;
        if (reset && misr_req_val && misr_req_rdy) n_reqs++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] misr_f(input logic [31:0] s,
                                           input logic [31:0] w);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [5:0] n);
        int t;
        t = 0;
        while (misr_req_rdy !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("req_rdy_wait", 32'(misr_req_rdy), 32'd1);
        misr_req_val = 1'b1;
        misr_req_msg = n;
        @(negedge clk);
        misr_req_val = 1'b0;
        chk("req_cut_rdy", 32'(cut_out_rdy), 32'(n != 0));
        chk("req_resp_val", 32'(misr_resp_val), 32'(n == 0));
        chk("req_rdy_low", 32'(misr_req_rdy), 32'd0);
    endtask

    task automatic send_words(input logic [31:0] w[$], input bit pat[$],
                              input logic [31:0] exp);
        int i;
        int k;
        bit v;
        i = 0;
        k = 0;
        exp_q.push_back(exp);
        while (i < w.size()) begin
            v = (k < pat.size()) ? pat[k] : 1'b1;
            k++;
            chk("hash_cut_rdy", 32'(cut_out_rdy), 32'd1);
            chk("hash_resp_val", 32'(misr_resp_val), 32'd0);
            cut_out_val = v;
            cut_out_msg = v ? w[i] : 32'hDEAD_BEEF;
            if (v) i++;
            @(negedge clk);
        end
        cut_out_val = 1'b0;
        chk("done_resp_val", 32'(misr_resp_val), 32'd1);
        chk("done_cut_rdy", 32'(cut_out_rdy), 32'd0);
        chk("sig", misr_resp_msg, exp_q.pop_front());
    endtask

    task automatic get_resp(input int hold);
        logic [31:0] m;
        m = misr_resp_msg;
        misr_resp_rdy = 1'b0;
        repeat (hold) begin
            chk("hold_resp_val", 32'(misr_resp_val), 32'd1);
            chk("hold_resp_msg", misr_resp_msg, m);
            chk("hold_req_rdy", 32'(misr_req_rdy), 32'd0);
            chk("hold_cut_rdy", 32'(cut_out_rdy), 32'd0);
            @(negedge clk);
        end
        misr_resp_rdy = 1'b1;
        @(negedge clk);
        misr_resp_rdy = 1'b0;
        chk("idle_req_rdy", 32'(misr_req_rdy), 32'd1);
        chk("idle_resp_val", 32'(misr_resp_val), 32'd0);
    endtask

    initial begin
        logic [31:0] w[$];
        logic [31:0] w3[$];
        logic [31:0] w32[$];
        bit          nopat[$];
        bit          gpat[$];
        logic [31:0] e;
        int          wb;
        int          rb;

        reset         = 1'b0;
        misr_req_val  = 1'b0;
        misr_req_msg  = '0;
        cut_out_val   = 1'b0;
        cut_out_msg   = '0;
        misr_resp_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_rdy", 32'(misr_req_rdy), 32'd1);
        chk("rst_cut_rdy", 32'(cut_out_rdy), 32'd0);
        chk("rst_resp_val", 32'(misr_resp_val), 32'd0);
        chk("rst_resp_msg", misr_resp_msg, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        send_req(6'd2);
        w = '{32'h8000_0000, 32'h0000_0000};
        send_words(w, nopat, 32'h04C1_1DB7);
        get_resp(0);

        send_req(6'd2);
        w = '{32'h1, 32'h1};
        send_words(w, nopat, 32'h0000_0003);
        get_resp(0);

        send_req(6'd2);
        w = '{32'h1, 32'h2};
        send_words(w, nopat, 32'h0000_0000);
        get_resp(0);

        send_req(6'd0);
        chk("zero_sig", misr_resp_msg, 32'h0);
        get_resp(1);

        w3 = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F};
        e = 32'h0;
        foreach (w3[i]) e = misr_f(e, w3[i]);
        send_req(6'd3);
        send_words(w3, nopat, e);
        get_resp(0);
        gpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        send_req(6'd3);
        send_words(w3, gpat, e);
        get_resp(4);

        w32.delete();
        e = 32'h0;
        for (int i = 0; i < 32; i++) begin
            w32.push_back($urandom);
            e = misr_f(e, w32[i]);
        end
        wb = n_words;
        rb = n_reqs;
        misr_req_val = 1'b1;
        misr_req_msg = 6'd32;
        @(negedge clk);
        misr_req_msg = 6'd1;
        send_words(w32, nopat, e);
        get_resp(2);
        chk("max_words", 32'(n_words - wb), 32'd32);
        chk("max_no_early_req", 32'(n_reqs - rb), 32'd1);
        @(negedge clk);
        misr_req_val = 1'b0;
        chk("b2b_req", 32'(n_reqs - rb), 32'd2);
        chk("b2b_cut_rdy", 32'(cut_out_rdy), 32'd1);
        wb = n_words;
        w = '{32'h5A};
        send_words(w, nopat, 32'h5A);
        get_resp(0);
        chk("b2b_words", 32'(n_words - wb), 32'd1);

        send_req(6'd8);
        for (int i = 0; i < 5; i++) begin
            cut_out_val = 1'b1;
            cut_out_msg = 32'(i + 7);
            @(negedge clk);
        end
        cut_out_val = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_req_rdy", 32'(misr_req_rdy), 32'd1);
        chk("arst_cut_rdy", 32'(cut_out_rdy), 32'd0);
        chk("arst_resp_val", 32'(misr_resp_val), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_req(6'd1);
        w = '{32'hA5};
        send_words(w, nopat, 32'h0000_00A5);
        get_resp(0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lbist_misr.md
# lbist_misr

Multiple-input signature register (MISR) that serves the LBIST controller's signature request/response interface. It accepts a request carrying the number of circuit-under-test (CUT) outputs to compress. It then consumes that many CUT output words over a val/rdy stream, folds them into a signature, and returns the signature to the controller over a val/rdy response. It sits between the CUT output port and the LBIST controller, one instance per CUT.

## Interface
- SIGNATURE_BITS, 32, width of signature register and response message
- CUT_OUTPUT_BITS, 32, width of one CUT output word; must be ≤ SIGNATURE_BITS
- MAX_OUTPUTS_TO_HASH, 32, largest request count honoured
- MISR_MSG_BITS, $clog2(MAX_OUTPUTS_TO_HASH), request count width minus one
- POLY, 32'h04C1_1DB7, feedback polynomial (low SIGNATURE_BITS bits used)

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; 0 resets immediately, independent of clk
- misr_req_val  in  1  request valid
- misr_req_rdy  out  1  ready for request
- misr_req_msg  in  MISR_MSG_BITS+1  number of CUT outputs to hash
- cut_out_val  in  1  CUT output word valid
- cut_out_rdy  out  1  MISR accepting CUT words
- cut_out_msg  in  CUT_OUTPUT_BITS  CUT output word
- misr_resp_val  out  1  signature valid
- misr_resp_rdy  in  1  controller ready for signature
- misr_resp_msg  out  SIGNATURE_BITS  signature

## Operation
- States: IDLE, HASH, DONE.
- Outputs are Moore (state-only). There is no combinational path from any input to any output.
- IDLE:
  - misr_req_rdy=1; cut_out_rdy=0; misr_resp_val=0.
  - On misr_req_val&&misr_req_rdy: latch target = min(misr_req_msg, MAX_OUTPUTS_TO_HASH); clear signature to 0; clear count to 0.
  - Next state is HASH if target≠0, otherwise DONE.
- HASH:
  - cut_out_rdy=1; misr_req_rdy=0; misr_resp_val=0.
  - Each cut_out_val&&cut_out_rdy cycle updates the signature: sig ← {sig[SB-2:0],1'b0} ^ (sig[SB-1] ? POLY : 0) ^ zero_extend(cut_out_msg); count ← count+1.
  - When the handshake occurs with count==target-1, next state is DONE.
  - Cycles with cut_out_val=0 leave sig and count unchanged.
- DONE:
  - misr_resp_val=1; misr_resp_msg=sig, held stable until accepted; misr_req_rdy=0; cut_out_rdy=0.
  - On misr_resp_rdy: next state IDLE.
  - sig keeps its value in IDLE until the next request clears it.
- The count register is MISR_MSG_BITS+1 wide, so it never wraps for any legal target.
- A misr_req_val outside IDLE is ignored and not buffered. CUT words outside HASH are not consumed.
- A misr_resp_msg value seen while misr_resp_val=0 carries no meaning; the bench must not check it.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, sig=0, count=0, target=0. Outputs: misr_req_rdy=1, cut_out_rdy=0, misr_resp_val=0, misr_resp_msg=0.
- Reset asserted mid-HASH or mid-DONE aborts the operation immediately. A pending signature is discarded.
- Request accepted at edge t: cut_out_rdy=1 in cycle t+1.
- Sustained throughput is one CUT word per cycle.
- Last CUT word accepted at edge u: misr_resp_val=1 in cycle u+1.
- Target 0 accepted at edge t: misr_resp_val=1 in cycle t+1 with signature 0.
- Response accepted at edge v: misr_req_rdy=1 in cycle v+1. The minimum gap between responses is one IDLE cycle.
- Request handshake and response handshake can never occur in the same cycle, because they belong to disjoint states.

## Test plan
- Reset, then request 2 with words 0x8000_0000, 0x0000_0000 and resp_rdy=1 → misr_resp_val one cycle after the 2nd word, misr_resp_msg=0x04C1_1DB7, then IDLE.
- Request 2 with words 0x1, 0x1 → signature 0x0000_0003. Request 2 with words 0x1, 0x2 → signature 0x0000_0000.
- Request 0 → misr_resp_val=1 the next cycle with msg 0, and cut_out_rdy is never asserted.
- Request 3 with cut_out_val gapped (1,0,0,1,0,1) and resp_rdy held 0 for 4 cycles → same signature as the gapless case. misr_resp_val and misr_resp_msg stay stable until resp_rdy=1, and req_rdy stays 0 meanwhile.
- Request count MAX_OUTPUTS_TO_HASH (32), then a second back-to-back request of 1 → exactly 32 words consumed, then exactly 1. misr_req_val held high during HASH/DONE is not accepted early.
- Assert reset=0 asynchronously (between edges) after 5 of 8 words → immediately req_rdy=1, cut_out_rdy=0, resp_val=0. A new request of 1 with word 0xA5 → signature 0x0000_00A5.
